// File: rtl/persiana_motion_scheduler.sv
// persiana_motion_scheduler: blind motor sequencer.
// Resolves manual/automatic commands into a target zone, tracks the blind
// zone from the three limit sensors, and drives mutually exclusive raise/lower
// outputs with a reversal dead-time and a travel timeout. All state advances
// only on clk edges where tick=1.
// Optional macro SENSOR_DEBOUNCE_EN: when defined, the limit sensors pass
// through a 2-flop synchronizer and a 3-sample tick-rate filter; when
// undefined they are used raw.
module persiana_motion_scheduler #(
  parameter int unsigned DEAD_TICKS    = 2,
  parameter int unsigned TIMEOUT_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cmd_cerrar,
  input  logic       cmd_medio,
  input  logic       cmd_abrir,
  input  logic       cmd_auto,
  input  logic [1:0] sensor,
  input  logic       s_sup,
  input  logic       s_med,
  input  logic       s_inf,
  output logic       subir,
  output logic       bajar,
  output logic [2:0] zone,
  output logic       fault,
  output logic       busy
);

  localparam logic [2:0] ST_HOME  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_UP    = 3'd2;
  localparam logic [2:0] ST_DOWN  = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [2:0] Z_BOTTOM  = 3'd0;
  localparam logic [2:0] Z_LOW     = 3'd1;
  localparam logic [2:0] Z_MID     = 3'd2;
  localparam logic [2:0] Z_HIGH    = 3'd3;
  localparam logic [2:0] Z_TOP     = 3'd4;
  localparam logic [2:0] Z_UNKNOWN = 3'd7;

  // Last count value before the dead-time / timeout expires.
  localparam logic [3:0] DEAD_LAST = 4'(DEAD_TICKS - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_TICKS - 1);

  logic [2:0] sens_raw;  // {s_sup, s_med, s_inf}
  logic [2:0] sens;      // sensor levels the zone logic acts on

  assign sens_raw = {s_sup, s_med, s_inf};

`ifdef SENSOR_DEBOUNCE_EN
  logic [2:0] sync1_q, sync2_q, hist0_q, hist1_q, filt_q;
  logic [2:0] agree;

  // A sensor bit is accepted once three consecutive tick samples agree.
  assign agree = ~(sync2_q ^ hist0_q) & ~(hist0_q ^ hist1_q);

  // Synchronize every clk, sample and filter on tick edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      sync1_q <= sens_raw;
      sync2_q <= sync1_q;
      if (tick) begin
        hist0_q <= sync2_q;
        hist1_q <= hist0_q;
        filt_q  <= (filt_q & ~agree) | (sync2_q & agree);
      end
    end
  end

  assign sens = filt_q;
`else
  assign sens = sens_raw;
`endif

  logic [2:0] state_q, state_d;
  logic [2:0] zone_q, zone_d, zone_upd;
  logic [2:0] target_q, target_d;
  logic       subir_q, subir_d, bajar_q, bajar_d;
  logic       fault_q, busy_q;
  logic [3:0] dead_q, dead_d;
  logic [7:0] tmo_q, tmo_d;

  logic       req_stop;
  logic [2:0] req_tgt;
  logic       want_up, want_dn;
  logic       dir_up, dir_dn;
  logic       conflict, moving, timeout, dead_done, start;

  assign conflict  = (sens[2] & sens[1]) | (sens[2] & sens[0]) | (sens[1] & sens[0]);
  assign moving    = subir_q | bajar_q;
  assign timeout   = moving && (tmo_q == TMO_LAST);
  assign dead_done = (dead_q == DEAD_LAST);

  // Command resolution: one-hot manual beats auto; anything else means stop.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    req_stop = 1'b0;
    req_tgt  = target_q;
    case ({cmd_cerrar, cmd_medio, cmd_abrir})
      3'b100: req_tgt = Z_BOTTOM;
      3'b010: req_tgt = Z_MID;
      3'b001: req_tgt = Z_TOP;
      3'b000: begin
        if (!cmd_auto) begin
          req_stop = 1'b1;
        end else begin
          case (sensor)
            2'b01:   req_tgt = Z_BOTTOM;
            2'b10:   req_tgt = Z_MID;
            2'b11:   req_tgt = Z_TOP;
            default: req_tgt = target_q;
          endcase
        end
      end
      default: req_stop = 1'b1;
    endcase
  end

  assign want_up = !req_stop && (req_tgt > zone_q);
  assign want_dn = !req_stop && (req_tgt < zone_q);

  // Direction the blind is travelling or starting to travel on this tick.
  always_comb begin
    dir_up = 1'b0;
    dir_dn = 1'b0;
    case (state_q)
      ST_HOME, ST_UP: dir_up = 1'b1;
      ST_DOWN:        dir_dn = 1'b1;
      ST_IDLE: begin
        dir_up = want_up;
        dir_dn = want_dn;
      end
      ST_DEAD: begin
        dir_up = dead_done && want_up;
        dir_dn = dead_done && want_dn;
      end
      default: ;
    endcase
  end

  // Zone tracking: a sensor pins the zone, leaving a sensor zone moves to the in-between zone.
  always_comb begin
    zone_upd = zone_q;
    if (sens[0])                          zone_upd = Z_BOTTOM;
    else if (sens[1])                     zone_upd = Z_MID;
    else if (sens[2])                     zone_upd = Z_TOP;
    else if (dir_up && zone_q == Z_BOTTOM) zone_upd = Z_LOW;
    else if (dir_up && zone_q == Z_MID)    zone_upd = Z_HIGH;
    else if (dir_dn && zone_q == Z_TOP)    zone_upd = Z_HIGH;
    else if (dir_dn && zone_q == Z_MID)    zone_upd = Z_LOW;
  end

  // Motion FSM and counters; nothing moves unless tick is high.
  always_comb begin
    state_d  = state_q;
    zone_d   = zone_q;
    target_d = target_q;
    subir_d  = subir_q;
    bajar_d  = bajar_q;
    dead_d   = dead_q;
    tmo_d    = tmo_q;
    start    = 1'b0;
    if (tick && state_q != ST_FAULT) begin
      if (conflict) begin
        state_d = ST_FAULT;
        subir_d = 1'b0;
        bajar_d = 1'b0;
      end else begin
        zone_d   = zone_upd;
        target_d = req_stop ? zone_upd : req_tgt;
        case (state_q)
          ST_HOME: begin
            target_d = zone_upd;
            if (sens[2]) begin
              state_d = ST_IDLE;
              subir_d = 1'b0;
            end else if (timeout) begin
              state_d = ST_FAULT;
              subir_d = 1'b0;
            end else begin
              subir_d = 1'b1;
              tmo_d   = tmo_q + {7'd0, moving};
            end
          end
          ST_IDLE: start = 1'b1;
          ST_DEAD: begin
            subir_d = 1'b0;
            bajar_d = 1'b0;
            if (dead_done) start = 1'b1;
            else           dead_d = dead_q + 4'd1;
          end
          ST_UP: begin
            if (req_stop || zone_upd == req_tgt) begin
              state_d = ST_IDLE;
              subir_d = 1'b0;
            end else if (req_tgt < zone_upd) begin
              state_d = ST_DEAD;
              subir_d = 1'b0;
              dead_d  = '0;
            end else if (timeout) begin
              state_d = ST_FAULT;
              subir_d = 1'b0;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
          ST_DOWN: begin
            if (req_stop || zone_upd == req_tgt) begin
              state_d = ST_IDLE;
              bajar_d = 1'b0;
            end else if (req_tgt > zone_upd) begin
              state_d = ST_DEAD;
              bajar_d = 1'b0;
              dead_d  = '0;
            end else if (timeout) begin
              state_d = ST_FAULT;
              bajar_d = 1'b0;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
          default: begin
            state_d = ST_FAULT;
            subir_d = 1'b0;
            bajar_d = 1'b0;
          end
        endcase
        if (start) begin
          if (want_up) begin
            state_d = ST_UP;
            subir_d = 1'b1;
            tmo_d   = '0;
          end else if (want_dn) begin
            state_d = ST_DOWN;
            bajar_d = 1'b1;
            tmo_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  // State and output registers; reset drops the motor outputs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is written with non-blocking assignments so all
      // registers update together from the values sampled before the edge.
      state_q  <= ST_HOME;
      zone_q   <= Z_UNKNOWN;
      target_q <= Z_TOP;
      subir_q  <= 1'b0;
      bajar_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b1;
      dead_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      zone_q   <= zone_d;
      target_q <= target_d;
      subir_q  <= subir_d;
      bajar_q  <= bajar_d;
      fault_q  <= (state_d == ST_FAULT);
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
      dead_q   <= dead_d;
      tmo_q    <= tmo_d;
    end
  end

  assign subir = subir_q;
  assign bajar = bajar_q;
  assign zone  = zone_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_persiana_motion_scheduler.sv
// Testbench for persiana_motion_scheduler: directed vector table, a few
// hand-written multi-cycle sequences, and randomized stimulus against a
// behavioural model of the blind.
module tb_persiana_motion_scheduler;

  localparam int DEAD = 2;
  localparam int TMO  = 8;

  localparam logic [3:0] NC = 4'b0000;  // {cerrar, medio, abrir, auto}
  localparam logic [3:0] C  = 4'b1000;
  localparam logic [3:0] M  = 4'b0100;
  localparam logic [3:0] A  = 4'b0010;
  localparam logic [3:0] AU = 4'b0001;
  localparam logic [2:0] NS  = 3'b000;  // {s_sup, s_med, s_inf}
  localparam logic [2:0] SUP = 3'b100;
  localparam logic [2:0] MED = 3'b010;
  localparam logic [2:0] INF = 3'b001;

  logic       clk = 1'b0;
  logic       reset, tick;
  logic       cmd_cerrar, cmd_medio, cmd_abrir, cmd_auto;
  logic [1:0] sensor;
  logic       s_sup, s_med, s_inf;
  logic       subir, bajar, fault, busy;
  logic [2:0] zone;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  persiana_motion_scheduler #(.DEAD_TICKS(DEAD), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .cmd_cerrar(cmd_cerrar), .cmd_medio(cmd_medio), .cmd_abrir(cmd_abrir), .cmd_auto(cmd_auto),
    .sensor(sensor), .s_sup(s_sup), .s_med(s_med), .s_inf(s_inf),
    .subir(subir), .bajar(bajar), .zone(zone), .fault(fault), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_out();
    return {subir, bajar, zone, fault, busy};
  endfunction

  task automatic drive(input logic rst, input logic tk, input logic [3:0] cmd,
                       input logic [1:0] sen, input logic [2:0] sens);
    reset = rst;
    tick  = tk;
    {cmd_cerrar, cmd_medio, cmd_abrir, cmd_auto} = cmd;
    sensor = sen;
    {s_sup, s_med, s_inf} = sens;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       tk;
    logic [3:0] cmd;
    logic [1:0] sen;
    logic [2:0] sens;
    logic [6:0] exp;  // {subir, bajar, zone, fault, busy} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic tk, input logic [3:0] cmd,
                     input logic [1:0] sen, input logic [2:0] sens,
                     input logic sub, input logic baj, input logic [2:0] z,
                     input logic f, input logic b);
    vec_t v;
    v.rst = rst; v.tk = tk; v.cmd = cmd; v.sen = sen; v.sens = sens;
    v.exp = {sub, baj, z, f, b};
    vecs.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  int m_zone, m_dir, m_dead, m_run, m_target;
  bit m_fault, m_home;

  task automatic model_reset();
    m_zone = 7; m_dir = 0; m_dead = 0; m_run = 0; m_target = 4;
    m_fault = 0; m_home = 1;
  endtask

  function automatic logic [6:0] model_out();
    logic s, b, bz;
    s  = (m_dir == 1);
    b  = (m_dir == -1);
    bz = !m_fault && (m_home || m_dir != 0 || m_dead != 0);
    return {s, b, 3'(m_zone), m_fault, bz};
  endfunction

  // One tick of the blind, computed from the inputs present before the edge.
  task automatic model_step();
    int tgt, intent, nz;
    bit stop, on;
    if (m_fault) return;
    if (int'(s_sup) + int'(s_med) + int'(s_inf) >= 2) begin
      m_fault = 1; m_dir = 0; m_dead = 0;
      return;
    end
    stop = 0;
    tgt  = m_target;
    case ({cmd_cerrar, cmd_medio, cmd_abrir})
      3'b100: tgt = 0;
      3'b010: tgt = 2;
      3'b001: tgt = 4;
      3'b000: begin
        if (!cmd_auto)        stop = 1;
        else if (sensor != 0) tgt = 2 * (int'(sensor) - 1);
      end
      default: stop = 1;
    endcase
    on = (m_dir != 0);
    if (m_home)          intent = 1;
    else if (on)         intent = m_dir;
    else if (m_dead > 1) intent = 0;
    else if (stop)       intent = 0;
    else                 intent = (tgt > m_zone) ? 1 : (tgt < m_zone) ? -1 : 0;
    if (s_inf)      nz = 0;
    else if (s_med) nz = 2;
    else if (s_sup) nz = 4;
    else if (intent != 0 && m_zone % 2 == 0 && m_zone + intent >= 0 && m_zone + intent <= 4)
      nz = m_zone + intent;
    else nz = m_zone;
    if (m_home) begin
      m_target = nz;
      if (s_sup) begin
        m_home = 0; m_dir = 0;
      end else begin
        m_dir = 1;
        if (on) begin
          m_run++;
          if (m_run == TMO) begin m_fault = 1; m_dir = 0; m_home = 0; end
        end
      end
    end else begin
      m_target = stop ? nz : tgt;
      if (on) begin
        if (stop || nz == tgt) m_dir = 0;
        else if ((tgt - nz) * m_dir < 0) begin m_dir = 0; m_dead = DEAD; end
        else begin
          m_run++;
          if (m_run == TMO) begin m_fault = 1; m_dir = 0; end
        end
      end else if (m_dead > 1) begin
        m_dead--;
      end else begin
        m_dead = 0; m_dir = intent; m_run = 0;
      end
    end
    m_zone = nz;
  endtask

  initial begin
    // Reset state, visible before any clock edge.
    drive(1, 0, NC, 2'b00, NS);
    #1;
    check("reset_state", 32'(dut_out()), 32'({1'b0, 1'b0, 3'd7, 1'b0, 1'b1}));
    step();

    // Homing, close with zone walk, auto mode, reversals, manual priority,
    // timeout, fault stickiness, reset from fault, sensor conflict.
    add(0, 1, NC, 0, NS,  1, 0, 7, 0, 1);
    add(0, 1, NC, 0, NS,  1, 0, 7, 0, 1);
    add(0, 1, NC, 0, SUP, 0, 0, 4, 0, 0);
    add(0, 0, C,  0, NS,  0, 0, 4, 0, 0);
    add(0, 1, C,  0, NS,  0, 1, 3, 0, 1);
    add(0, 1, C,  0, MED, 0, 1, 2, 0, 1);
    add(0, 1, C,  0, NS,  0, 1, 1, 0, 1);
    add(0, 1, C,  0, NS,  0, 1, 1, 0, 1);
    add(0, 1, C,  0, INF, 0, 0, 0, 0, 0);
    add(0, 1, AU, 2, NS,  1, 0, 1, 0, 1);
    add(0, 1, AU, 2, NS,  1, 0, 1, 0, 1);
    add(0, 1, AU, 2, NS,  1, 0, 1, 0, 1);
    add(0, 1, AU, 2, MED, 0, 0, 2, 0, 0);
    add(0, 1, AU, 0, NS,  0, 0, 2, 0, 0);
    add(0, 1, AU, 0, NS,  0, 0, 2, 0, 0);
    add(0, 1, C,  0, NS,  0, 1, 1, 0, 1);
    add(0, 1, A,  0, NS,  0, 0, 1, 0, 1);
    add(0, 1, A,  0, NS,  0, 0, 1, 0, 1);
    add(0, 1, A,  0, NS,  1, 0, 1, 0, 1);
    add(0, 1, A,  0, NS,  1, 0, 1, 0, 1);
    add(0, 1, C,  0, NS,  0, 0, 1, 0, 1);
    add(0, 1, C,  0, NS,  0, 0, 1, 0, 1);
    add(0, 1, C,  0, NS,  0, 1, 1, 0, 1);
    add(0, 1, C,  0, INF, 0, 0, 0, 0, 0);
    add(0, 1, M | AU, 1, NS, 1, 0, 1, 0, 1);
    add(0, 1, C | M,  0, NS, 0, 0, 1, 0, 0);
    for (int i = 0; i < TMO; i++) add(0, 1, A, 0, NS, 1, 0, 1, 0, 1);
    add(0, 1, A,  0, NS,  0, 0, 1, 1, 0);
    add(0, 1, C,  0, NS,  0, 0, 1, 1, 0);
    add(0, 1, C,  0, INF, 0, 0, 1, 1, 0);
    add(1, 1, NC, 0, NS,  0, 0, 7, 0, 1);
    add(0, 1, NC, 0, NS,  1, 0, 7, 0, 1);
    add(0, 1, NC, 0, SUP, 0, 0, 4, 0, 0);
    add(0, 1, NC, 0, SUP | INF, 0, 0, 4, 1, 0);
    add(1, 0, NC, 0, NS,  0, 0, 7, 0, 1);
    add(0, 1, NC, 0, NS,  1, 0, 7, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].tk, vecs[i].cmd, vecs[i].sen, vecs[i].sens);
      step();
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end

    // Homing that never sees s_sup: eight moving ticks, then timeout fault.
    drive(1, 1, NC, 0, NS);
    step();
    drive(0, 1, NC, 0, NS);
    for (int k = 1; k <= TMO; k++) begin
      step();
      check($sformatf("home_run%0d", k), 32'({subir, fault}), 32'(2'b10));
    end
    step();
    check("home_timeout", 32'({subir, bajar, fault, busy}), 32'(4'b0010));

    // Reset asserted between edges while homing: outputs drop at once.
    drive(1, 1, NC, 0, NS);
    step();
    drive(0, 1, NC, 0, NS);
    step();
    check("homing_before_drop", 32'(subir), 32'(1));
    reset = 1'b1;
    #1;
    check("async_drop", 32'(dut_out()), 32'({1'b0, 1'b0, 3'd7, 1'b0, 1'b1}));
    step();

    // Randomized run against the behavioural model.
    model_reset();
    begin
      logic [3:0] cmd;
      logic [1:0] sen;
      logic [2:0] sens;
      logic       rst, tk;
      int         p;
      cmd = NC;
      sen = 2'b00;
      for (int n = 0; n < 4000; n++) begin
        rst = ($urandom_range(0, 999) < 15);
        tk  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 6))
            0, 1, 2: cmd = {3'b100 >> $urandom_range(0, 2), 1'($urandom_range(0, 1))};
            3, 4:    cmd = AU;
            5:       cmd = NC;
            default: cmd = 4'($urandom_range(0, 15));
          endcase
          sen = 2'($urandom_range(0, 3));
        end
        p = $urandom_range(0, 999);
        if (p < 750)      sens = NS;
        else if (p < 830) sens = SUP;
        else if (p < 910) sens = MED;
        else if (p < 997) sens = INF;
        else              sens = (p == 997) ? (SUP | INF) : (MED | INF);
        drive(rst, tk, cmd, sen, sens);
        if (rst)     model_reset();
        else if (tk) model_step();
        step();
        check($sformatf("rand%0d", n), 32'(dut_out()), 32'(model_out()));
        check($sformatf("excl%0d", n), 32'(subir & bajar), 32'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
